// File: rtl/clink_pixel_packer.sv
// Camera Link pixel packer: packs accepted 3-tap pixel bytes into wide words,
// buffers them in a first-word-fall-through FIFO, and reports per-frame statistics.
module clink_pixel_packer #(
  parameter int DATA_WIDTH      = 128,
  parameter int BYTES_PER_WORD  = DATA_WIDTH/8,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                  px_clk,
  input  logic                  reset,
  input  logic                  capture_en,
  input  logic [7:0]            d0,
  input  logic [7:0]            d1,
  input  logic [7:0]            d2,
  input  logic                  fval,
  input  logic                  lval,
  input  logic                  dval,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  image_end,
  output logic                  frame_active,
  output logic                  overflow,
  output logic [15:0]           last_lines,
  output logic [31:0]           last_bytes,
  output logic [15:0]           frame_count
);
  localparam int BPW = BYTES_PER_WORD;
  localparam int CW  = $clog2(BPW) + 1;
  localparam int AW  = FIFO_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH_HOLD, FLUSH_PART} state_t;

  state_t                 state_q, state_d;
  logic                   fval_q, lval_q;
  logic [BPW-1:0][7:0]    acc_q, acc_d;
  logic [CW-1:0]          acc_cnt_q, acc_cnt_d;
  logic [BPW-1:0][7:0]    hold_q, hold_d;
  logic                   hold_vld_q, hold_vld_d;
  logic [15:0]            lines_q, lines_d;
  logic [31:0]            bytes_q, bytes_d;
  logic [15:0]            last_lines_q, last_bytes_hi_unused;
  logic [31:0]            last_bytes_q;
  logic [15:0]            frame_count_q;
  logic                   overflow_q;

  logic                   rise, fall, accept, line_rise, start, finish;
  logic                   wr_en, wr_last;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [BPW+2:0][7:0]    ext;
  logic [BPW-1:0][7:0]    rem;
  int                     acc_n, sum;
  logic                   word_done;

  assign rise      = fval & ~fval_q;
  assign fall      = ~fval & fval_q;
  assign accept    = fval & lval & dval;
  assign line_rise = lval & ~lval_q & fval;
  assign start     = (state_q == IDLE) & rise & capture_en;
  assign finish    = (state_q == FLUSH_PART);
  assign last_bytes_hi_unused = '0;

  // Append the three taps after the valid accumulator bytes; everything above stays zero.
  always_comb begin
    acc_n = int'(acc_cnt_q);
    sum   = acc_n + 3;
    ext   = '0;
    for (int i = 0; i < BPW + 3; i++) begin
      if (i < acc_n && i < BPW) ext[i] = acc_q[i];
      else if (i == acc_n)      ext[i] = d0;
      else if (i == acc_n + 1)  ext[i] = d1;
      else if (i == acc_n + 2)  ext[i] = d2;
    end
    word_done = (sum >= BPW);
    rem       = '0;
    rem[2:0]  = ext[BPW+2:BPW];
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    lines_d    = lines_q;
    bytes_d    = bytes_q;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    wr_data    = hold_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACTIVE;
          acc_d      = '0;
          acc_cnt_d  = '0;
          hold_vld_d = 1'b0;
          lines_d    = '0;
          bytes_d    = '0;
        end
      end
      ACTIVE: begin
        if (accept) begin
          bytes_d = (bytes_q >= 32'hFFFF_FFFD) ? 32'hFFFF_FFFF : bytes_q + 32'd3;
          if (word_done) begin
            // A previously held word is only known not to be the last once this one completes.
            wr_en      = hold_vld_q;
            hold_d     = ext[BPW-1:0];
            hold_vld_d = 1'b1;
            acc_d      = rem;
            acc_cnt_d  = CW'(sum - BPW);
          end else begin
            acc_d     = ext[BPW-1:0];
            acc_cnt_d = CW'(sum);
          end
        end
        if (line_rise && lines_q != 16'hFFFF) lines_d = lines_q + 16'd1;
        if (fall) state_d = FLUSH_HOLD;
      end
      FLUSH_HOLD: begin
        wr_en      = hold_vld_q;
        wr_last    = (acc_cnt_q == '0);
        hold_vld_d = 1'b0;
        state_d    = FLUSH_PART;
      end
      default: begin
        wr_en     = (acc_cnt_q != '0);
        wr_data   = acc_q;
        wr_last   = 1'b1;
        acc_d     = '0;
        acc_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Output FIFO with an extra pointer bit to tell full from empty.
  logic [DATA_WIDTH:0]  mem_q [FIFO_DEPTH];
  logic [AW:0]          wptr_q, rptr_q;
  logic                 empty, full, pop, push, drop;
  logic [DATA_WIDTH:0]  rd_word;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = ~empty & m_ready;
  assign push    = wr_en & (~full | pop);
  assign drop    = wr_en & full & ~pop;
  assign rd_word = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge px_clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {wr_last, wr_data};
  end

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fval_q        <= 1'b0;
      lval_q        <= 1'b0;
      acc_q         <= '0;
      acc_cnt_q     <= '0;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      lines_q       <= '0;
      bytes_q       <= '0;
      last_lines_q  <= '0;
      last_bytes_q  <= '0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      state_q    <= state_d;
      fval_q     <= fval;
      lval_q     <= lval;
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      lines_q    <= lines_d;
      bytes_q    <= bytes_d;
      if (finish) begin
        last_lines_q  <= lines_q;
        last_bytes_q  <= bytes_q;
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (start)     overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  assign m_valid      = ~empty;
  assign m_data       = m_valid ? rd_word[DATA_WIDTH-1:0] : '0;
  assign m_last       = m_valid & rd_word[DATA_WIDTH];
  assign image_end    = finish;
  assign frame_active = (state_q != IDLE);
  assign overflow     = overflow_q;
  assign last_lines   = last_lines_q | last_bytes_hi_unused;
  assign last_bytes   = last_bytes_q;
  assign frame_count  = frame_count_q;
endmodule

// File: tb/tb_clink_pixel_packer.sv
// Directed bench for clink_pixel_packer: frames of incrementing bytes checked
// word-by-word against hand-derived packing, plus statistics and overflow.
module tb_clink_pixel_packer;
  logic         px_clk = 1'b0;
  logic         reset, capture_en, fval, lval, dval, m_ready;
  logic [7:0]   d0, d1, d2;
  logic [127:0] m_data;
  logic         m_last, m_valid, image_end, frame_active, overflow;
  logic [15:0]  last_lines, frame_count;
  logic [31:0]  last_bytes;

  int tests = 0;
  int fails = 0;
  logic [128:0] got_q[$];
  int ie_cnt = 0;

  always #5 px_clk = ~px_clk;

  clink_pixel_packer #(.FIFO_DEPTH(4), .FIFO_ADDR_WIDTH(2)) dut (
    .px_clk(px_clk), .reset(reset), .capture_en(capture_en),
    .d0(d0), .d1(d1), .d2(d2), .fval(fval), .lval(lval), .dval(dval),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .image_end(image_end), .frame_active(frame_active), .overflow(overflow),
    .last_lines(last_lines), .last_bytes(last_bytes), .frame_count(frame_count)
  );

  initial begin : mon
    forever begin
      @(negedge px_clk);
      if (!reset) begin
        if (m_valid && m_ready) got_q.push_back({m_last, m_data});
        if (image_end) ie_cnt++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge px_clk);
    #1;
  endtask

  // Word k of a frame whose byte n carries value n; bytes past the frame end are zero.
  function automatic logic [127:0] exp_word(input int k, input int total);
    logic [127:0] w;
    w = '0;
    for (int j = 0; j < 16; j++) begin
      if (16 * k + j < total) w[8*j +: 8] = 8'(16 * k + j);
    end
    return w;
  endfunction

  task automatic run_frame(input int lines, input int accepts, input bit gaps, input bit arm);
    int b;
    b = 0;
    capture_en = arm;
    fval = 1'b1;
    tick;
    capture_en = 1'b1;
    tick;
    for (int l = 0; l < lines; l++) begin
      for (int a = 0; a < accepts; a++) begin
        lval = 1'b1; dval = 1'b1;
        d0 = 8'(b); d1 = 8'(b + 1); d2 = 8'(b + 2);
        b += 3;
        tick;
        if (gaps) begin
          dval = 1'b0; d0 = 8'hEE; d1 = 8'hEE; d2 = 8'hEE;
          tick;
        end
      end
      lval = 1'b0; dval = 1'b0;
      tick;
      if (gaps) repeat (2) tick;
    end
    fval = 1'b0;
    repeat (8) tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; capture_en = 1'b0; fval = 1'b0; lval = 1'b0; dval = 1'b0;
    m_ready = 1'b1; d0 = '0; d1 = '0; d2 = '0;
    repeat (3) tick;
    tests++;
    if ({m_valid, m_last, image_end, frame_active, overflow, last_lines, last_bytes, frame_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b l=%b ie=%b fa=%b ov=%b ll=%0d lb=%0d fc=%0d, required all 0",
               m_valid, m_last, image_end, frame_active, overflow, last_lines, last_bytes, frame_count);
    end
    tests++;
    if (m_data !== '0) begin fails++; $display("FAIL reset_data: got %h, required 0", m_data); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic(input int exp_fc);
    logic [128:0] e;
    got_q.delete(); ie_cnt = 0; m_ready = 1'b1;
    run_frame(2, 16, 1'b0, 1'b1);
    tests++;
    if (got_q.size() != 6) begin fails++; $display("FAIL basic_count: got %0d words, required 6", got_q.size()); end
    for (int k = 0; k < 6 && k < got_q.size(); k++) begin
      e = {k == 5, exp_word(k, 96)};
      tests++;
      if (got_q[k] !== e) begin fails++; $display("FAIL basic_word%0d: got %h, required %h", k, got_q[k], e); end
    end
    tests++;
    if (ie_cnt != 1) begin fails++; $display("FAIL basic_image_end: got %0d pulses, required 1", ie_cnt); end
    tests++;
    if (last_lines !== 16'd2) begin fails++; $display("FAIL basic_lines: got %0d, required 2", last_lines); end
    tests++;
    if (last_bytes !== 32'd96) begin fails++; $display("FAIL basic_bytes: got %0d, required 96", last_bytes); end
    tests++;
    if (frame_count !== 16'(exp_fc)) begin fails++; $display("FAIL basic_frames: got %0d, required %0d", frame_count, exp_fc); end
    tests++;
    if (overflow !== 1'b0 || frame_active !== 1'b0) begin
      fails++; $display("FAIL basic_flags: got ov=%b fa=%b, required 0 0", overflow, frame_active);
    end
  endtask

  task automatic test_partial;
    logic [128:0] e;
    got_q.delete(); ie_cnt = 0; m_ready = 1'b1;
    run_frame(1, 7, 1'b0, 1'b1);
    tests++;
    if (got_q.size() != 2) begin fails++; $display("FAIL partial_count: got %0d words, required 2", got_q.size()); end
    for (int k = 0; k < 2 && k < got_q.size(); k++) begin
      e = {k == 1, exp_word(k, 21)};
      tests++;
      if (got_q[k] !== e) begin fails++; $display("FAIL partial_word%0d: got %h, required %h", k, got_q[k], e); end
    end
    tests++;
    if (last_bytes !== 32'd21 || last_lines !== 16'd1) begin
      fails++; $display("FAIL partial_stats: got bytes=%0d lines=%0d, required 21 1", last_bytes, last_lines);
    end
    tests++;
    if (ie_cnt != 1 || frame_count !== 16'd2) begin
      fails++; $display("FAIL partial_end: got ie=%0d fc=%0d, required 1 2", ie_cnt, frame_count);
    end
  endtask

  task automatic test_gaps;
    logic [128:0] e;
    got_q.delete(); ie_cnt = 0; m_ready = 1'b1;
    run_frame(2, 16, 1'b1, 1'b1);
    tests++;
    if (got_q.size() != 6) begin fails++; $display("FAIL gaps_count: got %0d words, required 6", got_q.size()); end
    for (int k = 0; k < 6 && k < got_q.size(); k++) begin
      e = {k == 5, exp_word(k, 96)};
      tests++;
      if (got_q[k] !== e) begin fails++; $display("FAIL gaps_word%0d: got %h, required %h", k, got_q[k], e); end
    end
    tests++;
    if (last_bytes !== 32'd96 || last_lines !== 16'd2 || frame_count !== 16'd3 || ie_cnt != 1) begin
      fails++;
      $display("FAIL gaps_stats: got bytes=%0d lines=%0d fc=%0d ie=%0d, required 96 2 3 1",
               last_bytes, last_lines, frame_count, ie_cnt);
    end
  endtask

  task automatic test_overflow;
    logic [128:0] e;
    got_q.delete(); ie_cnt = 0; m_ready = 1'b0;
    run_frame(2, 16, 1'b0, 1'b1);
    tests++;
    if (overflow !== 1'b1 || m_valid !== 1'b1) begin
      fails++; $display("FAIL ovf_flag: got ov=%b v=%b, required 1 1", overflow, m_valid);
    end
    tests++;
    if (frame_count !== 16'd4 || ie_cnt != 1) begin
      fails++; $display("FAIL ovf_end: got fc=%0d ie=%0d, required 4 1", frame_count, ie_cnt);
    end
    m_ready = 1'b1;
    repeat (8) tick;
    tests++;
    if (got_q.size() != 4) begin fails++; $display("FAIL ovf_count: got %0d words, required 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      e = {1'b0, exp_word(k, 96)};
      tests++;
      if (got_q[k] !== e) begin fails++; $display("FAIL ovf_word%0d: got %h, required %h", k, got_q[k], e); end
    end
    tests++;
    if (overflow !== 1'b1 || m_valid !== 1'b0) begin
      fails++; $display("FAIL ovf_after_drain: got ov=%b v=%b, required 1 0", overflow, m_valid);
    end
  endtask

  task automatic test_disarmed;
    got_q.delete(); ie_cnt = 0; m_ready = 1'b1;
    run_frame(1, 7, 1'b0, 1'b0);
    tests++;
    if (got_q.size() != 0 || ie_cnt != 0) begin
      fails++; $display("FAIL disarmed_out: got words=%0d ie=%0d, required 0 0", got_q.size(), ie_cnt);
    end
    tests++;
    if (frame_count !== 16'd4 || last_bytes !== 32'd96) begin
      fails++; $display("FAIL disarmed_stats: got fc=%0d bytes=%0d, required 4 96", frame_count, last_bytes);
    end
    tests++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL disarmed_ovf: got %b, required 1", overflow); end
  endtask

  task automatic test_reset_mid;
    got_q.delete(); ie_cnt = 0; m_ready = 1'b1;
    capture_en = 1'b1; fval = 1'b1;
    tick;
    tick;
    tests++;
    if (frame_active !== 1'b1 || overflow !== 1'b0) begin
      fails++; $display("FAIL mid_start: got fa=%b ov=%b, required 1 0", frame_active, overflow);
    end
    for (int a = 0; a < 5; a++) begin
      lval = 1'b1; dval = 1'b1;
      d0 = 8'(3 * a); d1 = 8'(3 * a + 1); d2 = 8'(3 * a + 2);
      tick;
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({m_valid, m_last, image_end, frame_active, overflow, last_lines, last_bytes, frame_count} !== '0
        || m_data !== '0) begin
      fails++;
      $display("FAIL mid_reset: got v=%b fa=%b ov=%b ll=%0d lb=%0d fc=%0d, required all 0",
               m_valid, frame_active, overflow, last_lines, last_bytes, frame_count);
    end
    fval = 1'b0; lval = 1'b0; dval = 1'b0;
    tick;
    reset = 1'b0;
    repeat (2) tick;
    tests++;
    if (ie_cnt != 0) begin fails++; $display("FAIL mid_no_end: got %0d pulses, required 0", ie_cnt); end
  endtask

  initial begin
    test_reset;
    test_basic(1);
    test_partial;
    test_gaps;
    test_overflow;
    test_disarmed;
    test_reset_mid;
    test_basic(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
